esp_dma_mem_responder: RTL and testbench
========================================

// Module: esp_dma_mem_responder
// PURPOSE
//  Synthesizable DMA-side memory model sitting on the accelerator's DMA read/write ctrl+chnl ports (64-bit ESP style).
//  Serves read bursts from, and absorbs write bursts into, an internal word array.
//  A host backdoor port preloads operands and reads back results while the block is idle.
//  Used as the memory tile stand-in for test_rtl_basic_dma64-class accelerators in RTL benches and FPGA smoke builds.
// PARAMETERS
//  DEPTH        64  number of 64-bit words; addresses wrap modulo DEPTH (power of two)
//  RD_LATENCY    4  extra idle cycles before first read beat (used only with DMA_MEM_LATENCY_EN)
// PORTS
//  clk                        in   1   clock
//  rst_n                      in   1   asynchronous active-low reset
//  dma_read_ctrl_valid        in   1   read request valid
//  dma_read_ctrl_ready        out  1   read request accept
//  dma_read_ctrl_data_index   in   32  first word address
//  dma_read_ctrl_data_length  in   32  beats to return
//  dma_read_ctrl_data_size    in   3   beat size (ignored; always 64-bit)
//  dma_read_ctrl_data_user    in   6   ignored
//  dma_read_chnl_valid        out  1   read data valid
//  dma_read_chnl_ready        in   1   accelerator accepts beat
//  dma_read_chnl_data         out  64  read data
//  dma_write_ctrl_valid       in   1   write request valid
//  dma_write_ctrl_ready       out  1   write request accept
//  dma_write_ctrl_data_index  in   32  first word address
//  dma_write_ctrl_data_length in   32  beats to absorb
//  dma_write_ctrl_data_size   in   3   ignored
//  dma_write_ctrl_data_user   in   6   ignored
//  dma_write_chnl_valid       in   1   write data valid
//  dma_write_chnl_ready       out  1   block accepts beat
//  dma_write_chnl_data        in   64  write data
//  host_we                    in   1   backdoor write strobe
//  host_addr                  in   $clog2(DEPTH)  backdoor address
//  host_wdata                 in   64  backdoor write data
//  host_rdata                 out  64  backdoor read data, registered, 1-cycle latency
//  busy                       out  1   high whenever FSM not IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE; all ready/valid outputs 0; chnl_data, host_rdata, busy = 0; counters 0. Array contents not reset.
//  - FSM states: IDLE, RD_WAIT, RD_DATA, WR_DATA. Single outstanding transaction.
//  - IDLE: both ctrl_ready=1. Handshake = valid&&ready same cycle. Read and write ctrl valid together -> read wins, write ctrl_ready dropped that cycle (write stays pending).
//  - Read accept: latch addr=index mod DEPTH, remaining=length. length=0 -> stay IDLE, no beats. Else -> RD_WAIT.
//  - RD_WAIT: 1 cycle (fetch mem[addr] into data reg) -> RD_DATA. First chnl_valid exactly 2 cycles after ctrl handshake.
//  - RD_DATA: chnl_valid=1, data stable until chnl_ready. On beat: addr+1 (wrap DEPTH-1->0), remaining-1, next word loaded same edge so back-to-back beats at 1/cycle. Last beat -> IDLE, valid=0 next cycle.
//  - Write accept: latch addr/remaining; length=0 -> stay IDLE. Else -> WR_DATA.
//  - WR_DATA: chnl_ready=1; each valid beat writes mem[addr], addr wraps, remaining-1; last beat -> IDLE. Ctrl ready=0 throughout.
//  - Host port: host_we honoured only in IDLE and not on a cycle where a ctrl handshake occurs; otherwise write dropped. host_rdata <= mem[host_addr] every cycle (any state).
//  - length compared as full 32-bit unsigned; lengths > DEPTH legal, wrap and overwrite/re-read.
//  - Async reset mid-burst: FSM to IDLE immediately, burst abandoned, partially written words remain.
// CONFIGURATION
//  DMA_MEM_LATENCY_EN defined: RD_WAIT holds 1+RD_LATENCY cycles (first beat 2+RD_LATENCY cycles after ctrl handshake);
//   a down-counter counts out the wait. Write path unchanged.
//  Not defined: RD_WAIT is exactly 1 cycle; RD_LATENCY ignored, no counter logic generated.
// TESTING
//  1 Host load 0..15 at addr 0, read ctrl idx=0 len=16, chnl_ready=1 -> beats 0..15 back-to-back, first beat 2 cycles post-handshake.
//  2 Write ctrl idx=0 len=16 data 10,12,..,40 -> host readback addr 0..15 matches; busy low 1 cycle after last beat.
//  3 Read idx=62 len=4, DEPTH=64, chnl_ready toggling 1/0 -> data mem[62],mem[63],mem[0],mem[1], each held while ready=0.
//  4 Read and write ctrl valid same cycle -> read accepted first; write accepted in the IDLE cycle after read completes.
//  5 Read len=0 -> no chnl_valid ever, ctrl_ready back to 1 next cycle; host_we during WR_DATA -> memory unchanged.
//  6 rst_n low at beat 5 of len=16 read -> valid 0 immediately; after release new read idx=0 len=2 returns mem[0],mem[1].

Source files
------------

// File: rtl/esp_dma_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : esp_dma_mem_responder_if
// Purpose : 64-bit ESP-style DMA read/write bundle. It carries the ctrl and
//           chnl handshakes between an accelerator (master) and a memory
//           responder (slave).
// Ports   : read ctrl  valid/ready, data_index[31:0], data_length[31:0],
//                      data_size[2:0], data_user[5:0]
//           read chnl  valid/ready, data[63:0]
//           write ctrl valid/ready, data_index, data_length, data_size,
//                      data_user
//           write chnl valid/ready, data[63:0]
// Revision: 1.0  initial release
// ============================================================================
interface esp_dma_mem_responder_if;
  logic        dma_read_ctrl_valid;
  logic        dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index;
  logic [31:0] dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic [5:0]  dma_read_ctrl_data_user;
  logic        dma_read_chnl_valid;
  logic        dma_read_chnl_ready;
  logic [63:0] dma_read_chnl_data;
  logic        dma_write_ctrl_valid;
  logic        dma_write_ctrl_ready;
  logic [31:0] dma_write_ctrl_data_index;
  logic [31:0] dma_write_ctrl_data_length;
  logic [2:0]  dma_write_ctrl_data_size;
  logic [5:0]  dma_write_ctrl_data_user;
  logic        dma_write_chnl_valid;
  logic        dma_write_chnl_ready;
  logic [63:0] dma_write_chnl_data;

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
    input  dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
    input  dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
    input  dma_write_ctrl_data_size, dma_write_ctrl_data_user,
    input  dma_write_chnl_valid, dma_write_chnl_data,
    output dma_write_ctrl_ready, dma_write_chnl_ready
  );

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
    output dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
    output dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
    output dma_write_ctrl_data_size, dma_write_ctrl_data_user,
    output dma_write_chnl_valid, dma_write_chnl_data,
    input  dma_write_ctrl_ready, dma_write_chnl_ready
  );
endinterface
`default_nettype wire

// File: rtl/esp_dma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : esp_dma_mem_responder
// Purpose : DMA-side memory model for 64-bit ESP accelerators. It serves read
//           bursts from an internal word array and absorbs write bursts into
//           it. While idle, a host backdoor preloads and inspects the array.
// Ports   : clk, rst_n (async active-low)
//           dma        esp_dma_mem_responder_if.slave (read/write ctrl+chnl)
//           host_we, host_addr, host_wdata  backdoor write (IDLE only)
//           host_rdata registered backdoor read, 1-cycle latency
//           busy       FSM not in IDLE
// Config  : define DMA_MEM_LATENCY_EN to stretch RD_WAIT to 1+RD_LATENCY
//           cycles. This inserts RD_LATENCY extra cycles before the first
//           read beat.
// Revision: 1.0  initial release
// ============================================================================
module esp_dma_mem_responder #(
  parameter int DEPTH      = 64,
  parameter int RD_LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  esp_dma_mem_responder_if.slave   dma,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [63:0]              host_wdata,
  output logic [63:0]              host_rdata,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2,
    WR_DATA = 2'd3
  } state_t;

  state_t        state, next_state;
  logic [AW-1:0] addr, addr_inc;
  logic [31:0]   remaining;
  logic [63:0]   rd_data;
  logic [63:0]   mem [DEPTH];
  logic          rd_ctrl_ready, wr_ctrl_ready, rd_hs, wr_hs;
  logic          rd_chnl_valid, wr_chnl_ready;
  logic          fetch, last_beat, host_ok, dma_wr, mem_we;
  logic [AW-1:0] mem_waddr;
  logic [63:0]   mem_wdata;

  // Ctrl ready is held low while reset is asserted, so no request can
  // appear accepted during reset. A simultaneous read request takes
  // priority and masks the write ready.
  assign rd_ctrl_ready = rst_n && (state == IDLE);
  assign wr_ctrl_ready = rd_ctrl_ready && !dma.dma_read_ctrl_valid;
  assign rd_hs         = dma.dma_read_ctrl_valid && rd_ctrl_ready;
  assign wr_hs         = dma.dma_write_ctrl_valid && wr_ctrl_ready;
  assign last_beat     = (remaining == 32'd1);
  assign addr_inc      = addr + AW'(1);  // DEPTH is a power of two, so this wraps

`ifdef DMA_MEM_LATENCY_EN
  localparam int LAT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  logic [LAT_W-1:0] wait_cnt;

  // Down-counter loaded at read accept; the fetch fires once it reaches zero.
  assign fetch = (state == RD_WAIT) && (wait_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (rd_hs) begin
      wait_cnt <= LAT_W'(RD_LATENCY);
    end else if ((state == RD_WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - LAT_W'(1);
    end
  end
`else
  logic unused_rd_latency;
  assign unused_rd_latency = (RD_LATENCY != 0);
  assign fetch             = (state == RD_WAIT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    rd_chnl_valid = 1'b0;
    wr_chnl_ready = 1'b0;
    case (state)
      IDLE: begin
        if (rd_hs) begin
          if (dma.dma_read_ctrl_data_length != 32'd0) next_state = RD_WAIT;
        end else if (wr_hs) begin
          if (dma.dma_write_ctrl_data_length != 32'd0) next_state = WR_DATA;
        end
      end
      RD_WAIT: begin
        if (fetch) next_state = RD_DATA;
      end
      RD_DATA: begin
        rd_chnl_valid = 1'b1;
        if (dma.dma_read_chnl_ready && last_beat) next_state = IDLE;
      end
      WR_DATA: begin
        wr_chnl_ready = 1'b1;
        if (dma.dma_write_chnl_valid && last_beat) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Address/length tracking and the read data register. On each accepted read
  // beat the following word is loaded at the same edge, so beats can stream at
  // one per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      rd_data   <= '0;
    end else if (rd_hs) begin
      addr      <= dma.dma_read_ctrl_data_index[AW-1:0];
      remaining <= dma.dma_read_ctrl_data_length;
    end else if (wr_hs) begin
      addr      <= dma.dma_write_ctrl_data_index[AW-1:0];
      remaining <= dma.dma_write_ctrl_data_length;
    end else if (fetch) begin
      rd_data   <= mem[addr];
    end else if ((state == RD_DATA) && dma.dma_read_chnl_ready) begin
      addr      <= addr_inc;
      remaining <= remaining - 32'd1;
      rd_data   <= mem[addr_inc];
    end else if (dma_wr) begin
      addr      <= addr_inc;
      remaining <= remaining - 32'd1;
    end
  end

  // One write port is shared by DMA and host. They cannot collide, because
  // host writes are only allowed in IDLE and only when no ctrl handshake is
  // taking place.
  assign dma_wr    = (state == WR_DATA) && dma.dma_write_chnl_valid;
  assign host_ok   = host_we && (state == IDLE) && !rd_hs && !wr_hs;
  assign mem_we    = dma_wr || host_ok;
  assign mem_waddr = dma_wr ? addr : host_addr;
  assign mem_wdata = dma_wr ? dma.dma_write_chnl_data : host_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host_rdata <= '0;
    else        host_rdata <= mem[host_addr];
  end

  assign busy                     = (state != IDLE);
  assign dma.dma_read_ctrl_ready  = rd_ctrl_ready;
  assign dma.dma_write_ctrl_ready = wr_ctrl_ready;
  assign dma.dma_read_chnl_valid  = rd_chnl_valid;
  assign dma.dma_read_chnl_data   = rd_data;
  assign dma.dma_write_chnl_ready = wr_chnl_ready;

  logic unused_ctrl;
  assign unused_ctrl = ^{dma.dma_read_ctrl_data_index[31:AW], dma.dma_read_ctrl_data_size,
                         dma.dma_read_ctrl_data_user, dma.dma_write_ctrl_data_index[31:AW],
                         dma.dma_write_ctrl_data_size, dma.dma_write_ctrl_data_user};
endmodule
`default_nettype wire

// File: tb/tb_esp_dma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_esp_dma_mem_responder
// Purpose : Self-checking bench for esp_dma_mem_responder. Expected read data
//           comes from a reference word array and is queued when a read is
//           issued. Observed beats are queued as they arrive and are then
//           popped and compared.
// Revision: 1.0  initial release
// ============================================================================
module tb_esp_dma_mem_responder;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
`ifdef DMA_MEM_LATENCY_EN
  localparam int FIRST_LAT = 2 + 4;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [63:0]   host_wdata = '0;
  logic [63:0]   host_rdata;
  logic          busy;

  esp_dma_mem_responder_if dma();

  esp_dma_mem_responder #(.DEPTH(DEPTH), .RD_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .dma(dma), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [63:0] model [DEPTH];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [63:0] wr_data_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- drivers
  task automatic host_write(input int a, input logic [63:0] d);
    host_we = 1'b1; host_addr = AW'(a); host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    model[a] = d;
  endtask

  task automatic host_read(input int a, output logic [63:0] d);
    host_addr = AW'(a);
    @(negedge clk);
    d = host_rdata;
  endtask

  // Issues one read and collects the accepted beats into obs_q. It reports the
  // cycle of the first valid (counted from the handshake cycle), the span from
  // the first beat to the last beat, and any data change seen while stalled.
  task automatic run_read(input int idx, input int len, input bit toggle,
                          output int lat, output int span, output int hold_viol, output bit timeout);
    int n, beats, first_n;
    bit holding;
    logic [63:0] held;
    lat = -1; span = -1; hold_viol = 0; timeout = 1'b0; beats = 0; first_n = 0;
    holding = 1'b0; held = '0; n = 0;
    dma.dma_read_ctrl_valid = 1'b1;
    dma.dma_read_ctrl_data_index = idx;
    dma.dma_read_ctrl_data_length = len;
    #1;
    while (!dma.dma_read_ctrl_ready) begin
      @(negedge clk); #1; n++;
      if (n > 100) begin timeout = 1'b1; dma.dma_read_ctrl_valid = 1'b0; return; end
    end
    @(negedge clk);
    dma.dma_read_ctrl_valid = 1'b0;
    n = 1;
    while ((beats < len) || (len == 0 && n < 6)) begin
      dma.dma_read_chnl_ready = toggle ? n[0] : 1'b1;
      #1;
      if (dma.dma_read_chnl_valid) begin
        if (lat < 0) lat = n;
        if (holding && dma.dma_read_chnl_data !== held) hold_viol++;
        if (dma.dma_read_chnl_ready) begin
          obs_q.push_back(dma.dma_read_chnl_data);
          beats++;
          if (beats == 1) first_n = n;
          if (beats == len) span = n - first_n;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          held = dma.dma_read_chnl_data;
        end
      end
      @(negedge clk);
      n++;
      if (n > 300) begin timeout = 1'b1; break; end
    end
    dma.dma_read_chnl_ready = 1'b0;
  endtask

  // Issues one write using wr_data_q as the beat data. If poke is set, a host
  // write is attempted during the first WR_DATA cycle.
  task automatic run_write(input int idx, input int len, input bit poke, input int poke_addr,
                           output bit busy_after, output bit timeout);
    int n, beats;
    timeout = 1'b0; busy_after = 1'b1; n = 0; beats = 0;
    dma.dma_write_ctrl_valid = 1'b1;
    dma.dma_write_ctrl_data_index = idx;
    dma.dma_write_ctrl_data_length = len;
    #1;
    while (!dma.dma_write_ctrl_ready) begin
      @(negedge clk); #1; n++;
      if (n > 100) begin timeout = 1'b1; dma.dma_write_ctrl_valid = 1'b0; return; end
    end
    @(negedge clk);
    dma.dma_write_ctrl_valid = 1'b0;
    n = 1;
    while (beats < len) begin
      if (poke && n == 1) begin
        host_we = 1'b1; host_addr = AW'(poke_addr); host_wdata = 64'hDEAD_BEEF_0BAD_F00D;
      end else begin
        host_we = 1'b0;
      end
      dma.dma_write_chnl_valid = 1'b1;
      dma.dma_write_chnl_data = wr_data_q[beats];
      #1;
      if (dma.dma_write_chnl_ready) begin
        model[(idx + beats) % DEPTH] = wr_data_q[beats];
        beats++;
      end
      @(negedge clk);
      n++;
      if (n > 300) begin timeout = 1'b1; break; end
    end
    dma.dma_write_chnl_valid = 1'b0;
    host_we = 1'b0;
    #1;
    busy_after = busy;
    wr_data_q.delete();
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (dma.dma_read_ctrl_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ctrl_ready got=%b exp=0", dma.dma_read_ctrl_ready); end
    checks++; if (dma.dma_write_ctrl_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ctrl_ready got=%b exp=0", dma.dma_write_ctrl_ready); end
    checks++; if (dma.dma_read_chnl_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_chnl_valid got=%b exp=0", dma.dma_read_chnl_valid); end
    checks++; if (dma.dma_write_chnl_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_chnl_ready got=%b exp=0", dma.dma_write_chnl_ready); end
    checks++; if (dma.dma_read_chnl_data !== 64'd0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", dma.dma_read_chnl_data); end
    checks++; if (host_rdata !== 64'd0) begin errors++; $display("FAIL reset_host_rdata got=%h exp=0", host_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dma.dma_read_ctrl_ready !== 1'b1) begin errors++; $display("FAIL idle_rd_ctrl_ready got=%b exp=1", dma.dma_read_ctrl_ready); end
  endtask

  task automatic test_read_burst();
    int lat, span, hv; bit to; logic [63:0] e, o;
    for (int i = 0; i < 16; i++) host_write(i, 64'(i));
    for (int i = 0; i < 16; i++) exp_q.push_back(model[i]);
    run_read(0, 16, 1'b0, lat, span, hv, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rd16_timeout got=%b exp=0", to); end
    checks++; if (lat != FIRST_LAT) begin errors++; $display("FAIL rd16_first_latency got=%0d exp=%0d", lat, FIRST_LAT); end
    checks++; if (span != 15) begin errors++; $display("FAIL rd16_back_to_back span got=%0d exp=15", span); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rd16_data missing beat exp=%h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rd16_data got=%h exp=%h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rd16_extra_beats got=%0d exp=0", obs_q.size()); obs_q.delete(); end
    #1;
    checks++; if (dma.dma_read_chnl_valid !== 1'b0) begin errors++; $display("FAIL rd16_valid_after_last got=%b exp=0", dma.dma_read_chnl_valid); end
  endtask

  task automatic test_write_burst();
    bit ba, to; logic [63:0] d;
    for (int i = 0; i < 16; i++) wr_data_q.push_back(64'(10 + 2 * i));
    run_write(0, 16, 1'b0, 0, ba, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL wr16_timeout got=%b exp=0", to); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL wr16_busy_after_last got=%b exp=0", ba); end
    for (int i = 0; i < 16; i++) begin
      host_read(i, d); checks++;
      if (d !== 64'(10 + 2 * i)) begin errors++; $display("FAIL wr16_readback addr=%0d got=%h exp=%h", i, d, 64'(10 + 2 * i)); end
    end
  endtask

  task automatic test_wrap_stall();
    int lat, span, hv; bit to; logic [63:0] e, o;
    host_write(62, 64'hA5A5_0000_0000_003E);
    host_write(63, 64'h5A5A_0000_0000_003F);
    for (int i = 0; i < 4; i++) exp_q.push_back(model[(62 + i) % DEPTH]);
    run_read(62, 4, 1'b1, lat, span, hv, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL wrap_timeout got=%b exp=0", to); end
    checks++; if (hv != 0) begin errors++; $display("FAIL wrap_hold_stable violations got=%0d exp=0", hv); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL wrap_data missing beat exp=%h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL wrap_data got=%h exp=%h", o, e); end end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL wrap_extra_beats got=%0d exp=0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_priority();
    int lat, span, hv; bit to, ba; logic [63:0] e, o, d;
    dma.dma_write_ctrl_valid = 1'b1;
    dma.dma_write_ctrl_data_index = 32'd30;
    dma.dma_write_ctrl_data_length = 32'd2;
    dma.dma_read_ctrl_valid = 1'b1;
    dma.dma_read_ctrl_data_index = 32'd2;
    dma.dma_read_ctrl_data_length = 32'd3;
    #1;
    checks++; if (dma.dma_read_ctrl_ready !== 1'b1) begin errors++; $display("FAIL prio_rd_ready got=%b exp=1", dma.dma_read_ctrl_ready); end
    checks++; if (dma.dma_write_ctrl_ready !== 1'b0) begin errors++; $display("FAIL prio_wr_ready got=%b exp=0", dma.dma_write_ctrl_ready); end
    for (int i = 0; i < 3; i++) exp_q.push_back(model[2 + i]);
    run_read(2, 3, 1'b0, lat, span, hv, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL prio_rd_timeout got=%b exp=0", to); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL prio_rd_data missing beat exp=%h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL prio_rd_data got=%h exp=%h", o, e); end end
    end
    #1;
    checks++; if (dma.dma_write_ctrl_ready !== 1'b1) begin errors++; $display("FAIL prio_wr_ready_after_read got=%b exp=1", dma.dma_write_ctrl_ready); end
    wr_data_q.push_back(64'h1111); wr_data_q.push_back(64'h2222);
    run_write(30, 2, 1'b0, 0, ba, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL prio_wr_timeout got=%b exp=0", to); end
    host_read(31, d);
    checks++; if (d !== 64'h2222) begin errors++; $display("FAIL prio_wr_data got=%h exp=%h", d, 64'h2222); end
  endtask

  task automatic test_zero_len_and_host_block();
    int lat, span, hv; bit to, ba; logic [63:0] d;
    run_read(5, 0, 1'b0, lat, span, hv, to);
    checks++; if (lat != -1) begin errors++; $display("FAIL len0_valid_seen at cycle got=%0d exp=-1", lat); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL len0_beats got=%0d exp=0", obs_q.size()); obs_q.delete(); end
    #1;
    checks++; if (dma.dma_read_ctrl_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0_idle ready=%b busy=%b exp ready=1 busy=0", dma.dma_read_ctrl_ready, busy); end
    @(negedge clk);
    host_write(40, 64'h4040_4040_4040_4040);
    wr_data_q.push_back(64'hAAAA); wr_data_q.push_back(64'hBBBB);
    run_write(20, 2, 1'b1, 40, ba, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL hostblk_timeout got=%b exp=0", to); end
    host_read(40, d);
    checks++; if (d !== model[40]) begin errors++; $display("FAIL hostblk_mem40 got=%h exp=%h", d, model[40]); end
    host_read(21, d);
    checks++; if (d !== model[21]) begin errors++; $display("FAIL hostblk_mem21 got=%h exp=%h", d, model[21]); end
  endtask

  task automatic test_async_reset();
    int n, beats, lat, span, hv; bit to; logic [63:0] e, o;
    beats = 0; n = 0;
    dma.dma_read_ctrl_valid = 1'b1;
    dma.dma_read_ctrl_data_index = 32'd0;
    dma.dma_read_ctrl_data_length = 32'd16;
    dma.dma_read_chnl_ready = 1'b1;
    @(negedge clk);
    dma.dma_read_ctrl_valid = 1'b0;
    while (beats < 5 && n < 50) begin
      #1; if (dma.dma_read_chnl_valid) beats++;
      @(negedge clk); n++;
    end
    checks++; if (beats != 5) begin errors++; $display("FAIL arst_prefix_beats got=%0d exp=5", beats); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dma.dma_read_chnl_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", dma.dma_read_chnl_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
    dma.dma_read_chnl_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(model[0]); exp_q.push_back(model[1]);
    run_read(0, 2, 1'b0, lat, span, hv, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL arst_reread_timeout got=%b exp=0", to); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL arst_reread_data missing beat exp=%h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL arst_reread_data got=%h exp=%h", o, e); end end
    end
  endtask

  initial begin
    dma.dma_read_ctrl_valid = 1'b0;
    dma.dma_read_ctrl_data_index = '0;
    dma.dma_read_ctrl_data_length = '0;
    dma.dma_read_ctrl_data_size = 3'd3;
    dma.dma_read_ctrl_data_user = '0;
    dma.dma_read_chnl_ready = 1'b0;
    dma.dma_write_ctrl_valid = 1'b0;
    dma.dma_write_ctrl_data_index = '0;
    dma.dma_write_ctrl_data_length = '0;
    dma.dma_write_ctrl_data_size = 3'd3;
    dma.dma_write_ctrl_data_user = '0;
    dma.dma_write_chnl_valid = 1'b0;
    dma.dma_write_chnl_data = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    test_reset();
    for (int i = 0; i < DEPTH; i++) host_write(i, 64'h0);
    test_read_burst();
    test_write_burst();
    test_wrap_stall();
    test_priority();
    test_zero_len_and_host_block();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
